// File: rtl/stage_sequencer_if.sv
// Bundle of launch control, stage table config and
// per-stage parameter outputs for the stage sequencer.
interface stage_sequencer_if #(
  parameter int N          = 64,
  parameter int NUM_STAGES = 4
);
  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic          start;
  logic          abort;
  logic          ignition_end;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [N-1:0]  cfg_isp;
  logic [N-1:0]  cfg_prop;
  logic [N-1:0]  cfg_dry;
  logic [N-1:0]  cfg_burn;
  logic [N-1:0]  payload;

  logic [IW-1:0] stage_idx;
  logic          stage_load;
  logic [N-1:0]  isp;
  logic [N-1:0]  initial_weight;
  logic [N-1:0]  propellant_weight;
  logic [N-1:0]  burntime;
  logic          burning;
  logic          separating;
  logic          done;
  logic          aborted;

  modport master (
    output start, abort, ignition_end,
    output cfg_we, cfg_idx, cfg_isp, cfg_prop,
    output cfg_dry, cfg_burn, payload,
    input  stage_idx, stage_load, isp,
    input  initial_weight, propellant_weight,
    input  burntime, burning, separating,
    input  done, aborted
  );

  modport slave (
    input  start, abort, ignition_end,
    input  cfg_we, cfg_idx, cfg_isp, cfg_prop,
    input  cfg_dry, cfg_burn, payload,
    output stage_idx, stage_load, isp,
    output initial_weight, propellant_weight,
    output burntime, burning, separating,
    output done, aborted
  );
endinterface

// File: rtl/stage_sequencer.sv
// Multi-stage burn sequencer: sums vehicle mass, then
// steps through burn/separation per stage with watchdog.
module stage_sequencer #(
  parameter int N           = 64,
  parameter int NUM_STAGES  = 4,
  parameter int SEP_CYCLES  = 2,
  parameter int WDOG_MARGIN = 16
) (
  input logic               clk,
  input logic               resetb,
  stage_sequencer_if.slave  bus
);
  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  typedef enum logic [2:0] {
    IDLE, SUM, LOAD, BURN, SEP, DONE, ABORT
  } state_t;

  state_t state, state_nx;

  logic [N-1:0] isp_t  [NUM_STAGES];
  logic [N-1:0] prop_t [NUM_STAGES];
  logic [N-1:0] dry_t  [NUM_STAGES];
  logic [N-1:0] burn_t [NUM_STAGES];

  logic [N-1:0]  acc, acc_nx;
  logic [N-1:0]  cnt, cnt_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [N-1:0]  isp_q, prop_q, burn_q, wt_q;

  logic [IW-1:0] k;
  logic [N-1:0]  mass;
  logic [N-1:0]  limit;
  logic          last, skip, load;

  assign k     = cnt[IW-1:0];
  assign mass  = prop_t[idx] + dry_t[idx];
  assign limit = burn_q + N'(WDOG_MARGIN);
  assign last  = (idx == IW'(NUM_STAGES - 1));
  assign skip  = (burn_t[idx] == '0);
  assign load  = (state == LOAD) && !skip;

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    idx_nx   = idx;
    unique case (state)
      IDLE: if (bus.start) begin
        acc_nx   = bus.payload;
        cnt_nx   = '0;
        idx_nx   = '0;
        state_nx = SUM;
      end
      SUM: begin
        acc_nx = acc + prop_t[k] + dry_t[k];
        cnt_nx = cnt + 1'b1;
        if (k == IW'(NUM_STAGES - 1)) begin
          cnt_nx   = '0;
          idx_nx   = '0;
          state_nx = LOAD;
        end
      end
      LOAD: begin
        cnt_nx = '0;
        if (!skip) begin
          state_nx = BURN;
        end else begin
          // zero-burn stage is jettisoned without a burn
          acc_nx = acc - mass;
          if (last) state_nx = DONE;
          else      idx_nx   = idx + 1'b1;
        end
      end
      BURN: begin
        cnt_nx = cnt + 1'b1;
        if (bus.ignition_end) begin
          cnt_nx   = '0;
          state_nx = SEP;
        end else if (cnt + 1'b1 >= limit) begin
          state_nx = ABORT;
        end
      end
      SEP: begin
        if (cnt == '0) acc_nx = acc - mass;
        cnt_nx = cnt + 1'b1;
        if (cnt == N'(SEP_CYCLES - 1)) begin
          cnt_nx = '0;
          if (last) begin
            state_nx = DONE;
          end else begin
            idx_nx   = idx + 1'b1;
            state_nx = LOAD;
          end
        end
      end
      DONE:    state_nx = DONE;
      ABORT:   state_nx = ABORT;
      default: state_nx = IDLE;
    endcase
    if (bus.abort && (state == SUM || state == LOAD ||
                      state == BURN || state == SEP))
      state_nx = ABORT;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      idx    <= '0;
      isp_q  <= '0;
      prop_q <= '0;
      burn_q <= '0;
      wt_q   <= '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        isp_t[i]  <= '0;
        prop_t[i] <= '0;
        dry_t[i]  <= '0;
        burn_t[i] <= '0;
      end
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      if (load) begin
        isp_q  <= isp_t[idx];
        prop_q <= prop_t[idx];
        burn_q <= burn_t[idx];
        wt_q   <= acc;
      end
      if (state == IDLE && bus.cfg_we) begin
        isp_t[bus.cfg_idx]  <= bus.cfg_isp;
        prop_t[bus.cfg_idx] <= bus.cfg_prop;
        dry_t[bus.cfg_idx]  <= bus.cfg_dry;
        burn_t[bus.cfg_idx] <= bus.cfg_burn;
      end
    end
  end

  // parameters appear in the same cycle as the load pulse
  assign bus.stage_idx         = idx;
  assign bus.stage_load        = load;
  assign bus.isp               = load ? isp_t[idx]  : isp_q;
  assign bus.propellant_weight = load ? prop_t[idx] : prop_q;
  assign bus.burntime          = load ? burn_t[idx] : burn_q;
  assign bus.initial_weight    = load ? acc         : wt_q;
  assign bus.burning           = (state == BURN);
  assign bus.separating        = (state == SEP);
  assign bus.done              = (state == DONE);
  assign bus.aborted           = (state == ABORT);
endmodule

// File: tb/tb_stage_sequencer.sv
// Directed + randomized bench for stage_sequencer with a
// mass-budget reference model of the expected stage loads.
module tb_stage_sequencer;
  localparam int NS = 4;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  always #5 clk = ~clk;

  stage_sequencer_if #(.N(64), .NUM_STAGES(NS)) bus ();

  stage_sequencer #(
    .N(64), .NUM_STAGES(NS), .SEP_CYCLES(2), .WDOG_MARGIN(16)
  ) dut (
    .clk(clk),
    .resetb(resetb),
    .bus(bus)
  );

  typedef struct {
    int          idx;
    logic [63:0] isp;
    logic [63:0] prop;
    logic [63:0] burn;
    logic [63:0] wt;
  } exp_t;

  logic [63:0] t_isp [NS];
  logic [63:0] t_prop[NS];
  logic [63:0] t_dry [NS];
  logic [63:0] t_burn[NS];
  logic [63:0] pay;
  exp_t        expq[$];
  logic [63:0] obs_wt[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every stage's prop+dry rides on the stack until it is dropped;
  // stages with zero burn time are dropped without a load.
  task automatic build_model();
    logic [63:0] m;
    exp_t e;
    expq.delete();
    m = pay;
    for (int i = 0; i < NS; i++) m += t_prop[i] + t_dry[i];
    for (int i = 0; i < NS; i++) begin
      if (t_burn[i] != 0) begin
        e.idx = i; e.isp = t_isp[i]; e.prop = t_prop[i];
        e.burn = t_burn[i]; e.wt = m;
        expq.push_back(e);
      end
      m -= t_prop[i] + t_dry[i];
    end
  endtask

  task automatic configure();
    for (int i = 0; i < NS; i++) begin
      bus.cfg_we   = 1'b1;
      bus.cfg_idx  = 2'(i);
      bus.cfg_isp  = t_isp[i];
      bus.cfg_prop = t_prop[i];
      bus.cfg_dry  = t_dry[i];
      bus.cfg_burn = t_burn[i];
      step();
    end
    bus.cfg_we = 1'b0;
    bus.payload = pay;
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    step();
    resetb = 1'b1;
    step();
  endtask

  task automatic ref_table();
    t_prop = '{64'd2077000, 64'd456100, 64'd39136, 64'd83864};
    t_dry  = '{64'd137000, 64'd40100, 64'd0, 64'd15200};
    t_burn = '{64'd48, 64'd360, 64'd165, 64'd335};
    t_isp  = '{64'd263, 64'd421, 64'd228, 64'd311};
    pay    = 64'd27003;
  endtask

  task automatic run_mission(input bit noise);
    exp_t e;
    int bc;
    int d;
    bit fin;
    build_model();
    obs_wt.delete();
    bc = 0;
    d = int'($urandom_range(1, 8));
    fin = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (bus.stage_load) begin
        obs_wt.push_back(bus.initial_weight);
        chk("extra_load", 64'(expq.size() > 0), 64'd1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("load_idx", 64'(bus.stage_idx), 64'(e.idx));
          chk("load_isp", bus.isp, e.isp);
          chk("load_prop", bus.propellant_weight, e.prop);
          chk("load_burn", bus.burntime, e.burn);
          chk("load_wt", bus.initial_weight, e.wt);
        end
      end
      if (bus.burning) begin
        bc++;
      end else begin
        bc = 0;
        d = int'($urandom_range(1, 8));
      end
      bus.ignition_end = bus.burning && (bc == d);
      if (noise) begin
        bus.cfg_we   = 1'($urandom);
        bus.cfg_idx  = 2'($urandom);
        bus.cfg_isp  = {$urandom, $urandom};
        bus.cfg_prop = 64'($urandom);
        bus.cfg_dry  = 64'($urandom);
        bus.cfg_burn = 64'($urandom_range(0, 3));
      end
      fin = bus.done || bus.aborted;
      if (!fin) step();
    end
    bus.ignition_end = 1'b0;
    bus.cfg_we = 1'b0;
    chk("mission_done", 64'(bus.done), 64'd1);
    chk("mission_no_abort", 64'(bus.aborted), 64'd0);
    chk("loads_left", 64'(expq.size()), 64'd0);
  endtask

  task automatic wait_burning();
    int n = 0;
    while (!bus.burning && n < 50) begin
      step();
      n++;
    end
    chk("reach_burn", 64'(bus.burning), 64'd1);
  endtask

  initial begin
    int n;
    bit sep_seen;
    bus.start = 0; bus.abort = 0; bus.ignition_end = 0;
    bus.cfg_we = 0; bus.cfg_idx = 0; bus.cfg_isp = 0;
    bus.cfg_prop = 0; bus.cfg_dry = 0; bus.cfg_burn = 0;
    bus.payload = 0;
    #12;
    chk("rst_load", 64'(bus.stage_load), 64'd0);
    chk("rst_idx", 64'(bus.stage_idx), 64'd0);
    chk("rst_wt", bus.initial_weight, 64'd0);
    chk("rst_isp", bus.isp, 64'd0);
    chk("rst_flags", 64'({bus.burning, bus.separating,
                          bus.done, bus.aborted}), 64'd0);
    resetb = 1'b1;
    step();

    // load pulse latency after start
    ref_table();
    configure();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("early_load", 64'(bus.stage_load), 64'd0);
      step();
    end
    chk("load_at_4", 64'(bus.stage_load), 64'd1);
    chk("load_isp0", bus.isp, t_isp[0]);
    step();
    chk("load_one_cycle", 64'(bus.stage_load), 64'd0);
    chk("burn_after_load", 64'(bus.burning), 64'd1);
    chk("isp_held", bus.isp, t_isp[0]);

    // reference mission
    do_reset();
    ref_table();
    configure();
    run_mission(1'b0);
    chk("ref_loads", 64'(obs_wt.size()), 64'd4);
    if (obs_wt.size() == 4) begin
      chk("ref_wt0", obs_wt[0], 64'd2875403);
      chk("ref_wt1", obs_wt[1], 64'd661403);
      chk("ref_wt2", obs_wt[2], 64'd165203);
      chk("ref_wt3", obs_wt[3], 64'd126067);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    chk("done_sticky", 64'(bus.done), 64'd1);
    chk("done_no_load", 64'(bus.stage_load), 64'd0);

    // watchdog
    do_reset();
    ref_table();
    configure();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_burning();
    n = 0;
    while (bus.burning && n < 200) begin
      n++;
      step();
    end
    chk("wdog_cycles", 64'(n), 64'd64);
    chk("wdog_aborted", 64'(bus.aborted), 64'd1);
    chk("wdog_idx", 64'(bus.stage_idx), 64'd0);

    // abort beats ignition_end
    do_reset();
    ref_table();
    configure();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_burning();
    step();
    bus.abort = 1'b1;
    bus.ignition_end = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.ignition_end = 1'b0;
    sep_seen = bus.separating;
    for (int i = 0; i < 10; i++) begin
      step();
      sep_seen |= bus.separating;
    end
    chk("abort_state", 64'(bus.aborted), 64'd1);
    chk("abort_no_sep", 64'(sep_seen), 64'd0);
    chk("abort_no_burn", 64'(bus.burning), 64'd0);

    // zero-burn stage skipped
    do_reset();
    ref_table();
    t_burn[1] = 64'd0;
    configure();
    run_mission(1'b0);
    chk("skip_loads", 64'(obs_wt.size()), 64'd3);
    if (obs_wt.size() == 3)
      chk("skip_wt", obs_wt[1], 64'd165203);

    // reset during separation
    do_reset();
    ref_table();
    configure();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_burning();
    bus.ignition_end = 1'b1;
    step();
    bus.ignition_end = 1'b0;
    chk("in_sep", 64'(bus.separating), 64'd1);
    resetb = 1'b0;
    #1;
    chk("rstsep_wt", bus.initial_weight, 64'd0);
    chk("rstsep_isp", bus.isp, 64'd0);
    chk("rstsep_flags", 64'({bus.stage_load, bus.burning,
        bus.separating, bus.done, bus.aborted}), 64'd0);
    #3;
    resetb = 1'b1;
    t_isp[0] = 64'd777;
    configure();
    run_mission(1'b0);

    // randomized missions with cfg noise outside IDLE
    for (int r = 0; r < 5; r++) begin
      do_reset();
      for (int i = 0; i < NS; i++) begin
        t_isp[i]  = {$urandom, $urandom};
        t_prop[i] = {$urandom, $urandom};
        t_dry[i]  = 64'($urandom);
        t_burn[i] = ($urandom_range(0, 3) == 0) ? 64'd0
                    : 64'($urandom_range(1, 40));
      end
      pay = {$urandom, $urandom};
      configure();
      run_mission(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
